// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: width, scheduler states and
// ALU Control codes.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

endpackage

// File: rtl/ALU_4Bit.sv
// Shared combinational ALU: add/sub with carry/borrow, bitwise and/or.
module ALU_4Bit
  import alu_pkg::*;
(
  input  logic [1:0]       Control,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  output logic [ALU_W-1:0] nBitOut,
  output logic             CB
);

  logic [ALU_W:0] ext;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ext = '0;
    case (Control)
      OP_ADD:  ext = {1'b0, A} + {1'b0, B};
      // The extra MSB of a widened subtraction is the borrow (set when A < B).
      OP_SUB:  ext = {1'b0, A} - {1'b0, B};
      OP_AND:  ext = {1'b0, A & B};
      default: ext = {1'b0, A | B};
    endcase
  end

  assign nBitOut = ext[ALU_W-1:0];
  assign CB      = ext[ALU_W];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler granting the shared ALU to one of two requesters,
// registering its operands and returning the result via a held response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       ReqValid,
  output logic [1:0]       ReqReady,
  input  logic [1:0]       ReqOp0,
  input  logic [1:0]       ReqOp1,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic [WIDTH-1:0] ReqB1,
  output logic             RspValid,
  input  logic             RspReady,
  output logic             RspId,
  output logic [WIDTH-1:0] RspData,
  output logic             RspCB,
  output logic [CNT_W-1:0] OpCount
);

  if (WIDTH != ALU_W) begin : g_width_check
    $error("alu_arbiter: WIDTH must equal ALU_W");
  end

  state_t           state, next_state;
  logic             Prio;
  logic             IdReg;
  logic [1:0]       OpReg;
  logic [WIDTH-1:0] AReg, BReg;
  logic             grant;
  logic             req_fire, rsp_fire;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cb;

  // A lone valid requester wins outright; on contention Prio decides.
  always_comb begin
    if (ReqValid == 2'b10)      grant = 1'b1;
    else if (ReqValid == 2'b01) grant = 1'b0;
    else                        grant = Prio;
  end

  always_comb begin
    next_state = state;
    ReqReady   = '0;
    req_fire   = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (|ReqValid && !Reset) begin
          ReqReady[grant] = 1'b1;
          req_fire        = 1'b1;
          next_state      = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        if (RspReady) begin
          rsp_fire   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Prio    <= 1'b0;
      IdReg   <= 1'b0;
      OpReg   <= '0;
      AReg    <= '0;
      BReg    <= '0;
      RspData <= '0;
      RspCB   <= 1'b0;
      OpCount <= '0;
    end else begin
      if (req_fire) begin
        IdReg <= grant;
        OpReg <= grant ? ReqOp1 : ReqOp0;
        AReg  <= grant ? ReqA1  : ReqA0;
        BReg  <= grant ? ReqB1  : ReqB0;
      end
      if (state == EXEC) begin
        RspData <= alu_out;
        RspCB   <= alu_cb;
      end
      if (rsp_fire) begin
        OpCount <= OpCount + CNT_W'(1);
        Prio    <= ~IdReg;
      end
    end
  end

  ALU_4Bit u_alu (
    .Control (OpReg),
    .A       (AReg),
    .B       (BReg),
    .nBitOut (alu_out),
    .CB      (alu_cb)
  );

  assign RspValid = (state == RESP);
  assign RspId    = IdReg;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester scheduler for the shared 16-bit ALU (`ALU_4Bit`). It grants the ALU to one requester at a time using round-robin priority and registers the selected operation and operands. It captures the ALU result and carry/borrow, then returns them through a held response handshake. It sits between the datapath's two operation sources and the single ALU instance, which it owns.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width. Must equal the ALU width; any other value is an elaboration error.
- `CNT_W`, 16: width of the completed-operation counter.

Ports (clock and reset first):
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ReqValid[1:0]`  in  2  per-requester request valid.
- `ReqReady[1:0]`  out  2  per-requester accept; at most one bit high.
- `ReqOp0`, `ReqOp1`  in  2 each  ALU Control code. Passed to the ALU unmodified.
- `ReqA0`, `ReqA1`  in  WIDTH each  operand A.
- `ReqB0`, `ReqB1`  in  WIDTH each  operand B.
- `RspValid`  out  1  response available.
- `RspReady`  in  1  consumer accepts the response.
- `RspId`  out  1  index of the requester that owns the response.
- `RspData`  out  WIDTH  captured ALU result.
- `RspCB`  out  1  captured ALU carry/borrow.
- `OpCount`  out  CNT_W  count of completed responses; wraps.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant: if exactly one `ReqValid` bit is set, that requester is granted. If both are set, the requester indicated by `Prio` is granted.
  - `ReqReady[g] = 1` only for the granted requester, and only in IDLE with `Reset` low.
  - On handshake (`ReqValid[g] & ReqReady[g]`):
    - latch op, A, B into `OpReg`/`AReg`/`BReg`;
    - latch g into `IdReg`;
    - move to EXEC.
- **EXEC**
  - The ALU is driven from the latched registers only; live request inputs are never applied to the ALU.
  - Capture ALU `nBitOut` into `RspData` and `CB` into `RspCB`; move to RESP.
- **RESP**
  - `RspValid = 1`; `RspId = IdReg`.
  - `RspData`/`RspCB` stay stable until the handshake.
  - On `RspValid & RspReady`:
    - return to IDLE;
    - `OpCount` increments, wrapping from all-ones to 0;
    - `Prio` becomes the other requester (`Prio <= ~IdReg`).
- `ReqReady` is 0 in EXEC and RESP. A requester may drop `ReqValid` before `ReqReady` with no effect.
- Reset values, all outputs and state:
  - FSM = IDLE; `Prio` = 0.
  - `ReqReady` = 0 while `Reset` is high.
  - `RspValid` = 0, `RspId` = 0, `RspData` = 0, `RspCB` = 0, `OpCount` = 0.
  - Operand registers = 0.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded and no response is emitted. After deassertion the block is in IDLE with `Prio` = 0.

## Timing
- Request handshake at edge N → ALU evaluates during cycle N+1 → result registered at edge N+1 → `RspValid` high from cycle N+2.
- Minimum issue interval is 3 cycles, reached when `RspReady` is held high.
- `ReqReady` is combinational from `ReqValid`, state and `Prio`. There is no combinational path from request data to any output.
- `RspReady` is not consulted outside RESP.
- Back-to-back with both requesters always valid: grants alternate 0,1,0,1 starting with requester 0 after reset.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_W = 16`;
  - the state enum (IDLE, EXEC, RESP);
  - Control code constants: `OP_ADD = 2'b10`, `OP_SUB = 2'b11`, and the logic codes.
- One sub-module: a single instance of the existing `ALU_4Bit`, fed only from `OpReg`/`AReg`/`BReg`.
- Grant logic stays inline; a separate module is not warranted for two requesters.

## Test plan
- **Single add:** reset, then requester 0 sends `ReqOp0=OP_ADD`, A=0x0005, B=0x0003 → `RspValid` rises 2 cycles after the handshake, with `RspId=0`, `RspData=0x0008`, `RspCB=0`; `OpCount=1` after `RspReady`.
- **Subtract with borrow:** requester 1 sends `OP_SUB`, A=0x0003, B=0x0005 → `RspData=0xFFFE`, `RspCB=1`, `RspId=1`.
- **Add overflow:** `OP_ADD`, A=0xFFFF, B=0x0001 → `RspData=0x0000`, `RspCB=1`.
- **Contention:** both requesters hold `ReqValid=1` with `RspReady=1` for 4 operations → grant order 0,1,0,1. `ReqReady` is never high for both requesters, and is never high outside IDLE.
- **Response backpressure:** hold `RspReady=0` for 10 cycles while new requests are pending → `RspData`/`RspCB`/`RspId` are stable, `ReqReady=0` throughout, and no new grant occurs until the response handshake.
- **Reset and counter wrap:**
  - Assert `Reset` in RESP → outputs return to their reset values immediately; no response appears after release; the first grant goes to requester 0.
  - Preload `OpCount` to all-ones via 2^CNT_W−1 operations (or force) → the next completion reads 0.
